// File: rtl/bus_defs.sv
// Shared definitions for the bus cycle arbiter: bus widths, FSM state encoding,
// bus cycle kinds and the default EPROM window.
package bus_defs;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] EPROM_BASE_DEFAULT = 16'hF000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MEM_RD = 2'd0,
        MEM_WR = 2'd1,
        IO_RD  = 2'd2,
        IO_WR  = 2'd3
    } cycle_kind_t;

    // What the strobe phase needs to know about the granted cycle.
    typedef struct packed {
        cycle_kind_t kind;
        logic        suppress;
    } cycle_t;

    function automatic cycle_kind_t kind_of(input logic io, input logic we);
        cycle_kind_t k;
        case ({io, we})
            2'b00:   k = MEM_RD;
            2'b01:   k = MEM_WR;
            2'b10:   k = IO_RD;
            default: k = IO_WR;
        endcase
        return k;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_cycle_arbiter_if.sv
// Requester and system-bus signals of the bus cycle arbiter. The arbiter takes
// the slave view; requesters and the bus model take the master view.
interface bus_cycle_arbiter_if;
    import bus_defs::*;

    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0]        io;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [1:0]        err;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] d_out;
    logic              d_oe;
    logic [DATA_W-1:0] d_in;
    logic              mr_;
    logic              mw_;
    logic              ior_;
    logic              iow_;

    modport slave (
        input  req, we, io, addr0, addr1, wdata0, wdata1, d_in,
        output ack, err, rdata, busy,
        output bus_addr, d_out, d_oe, mr_, mw_, ior_, iow_
    );

    modport master (
        output req, we, io, addr0, addr1, wdata0, wdata1, d_in,
        input  ack, err, rdata, busy,
        input  bus_addr, d_out, d_oe, mr_, mw_, ior_, iow_
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie
// and moves to the loser of every grant.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       winner
);

    logic ptr;

    always_comb begin
        // NOTE: a default assignment first means no path leaves winner unassigned, so no latch.
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ptr;
            default: winner = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (grant_en && (|req)) begin
            ptr <= ~winner;
        end
    end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Arbitrates two requesters onto the shared bus and runs one complete
// setup / strobe / hold cycle per grant, with per-region wait states.
module bus_cycle_arbiter
    import bus_defs::*;
#(
    parameter int                RAM_WAIT   = 1,
    parameter int                EPROM_WAIT = 3,
    parameter int                IO_WAIT    = 2,
    parameter logic [ADDR_W-1:0] EPROM_BASE = EPROM_BASE_DEFAULT
) (
    input logic                clock,
    input logic                reset,
    bus_cycle_arbiter_if.slave bus
);

    localparam int MAX_WAIT = max3(RAM_WAIT, EPROM_WAIT, IO_WAIT);
    localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    state_t           state;
    cycle_t           cyc;
    logic             win_q;
    logic [CNT_W-1:0] wait_cnt;

    logic              winner;
    logic              grant_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    cycle_kind_t       sel_kind;
    logic              sel_eprom;
    logic [CNT_W-1:0]  sel_wait;

    rr_arbiter2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .req      (bus.req),
        .grant_en (grant_en),
        .winner   (winner)
    );

    assign grant_en = (state == IDLE);

    // Fields of whichever requester the arbiter is currently selecting.
    always_comb begin
        sel_addr  = winner ? bus.addr1  : bus.addr0;
        sel_wdata = winner ? bus.wdata1 : bus.wdata0;
        sel_kind  = kind_of(bus.io[winner], bus.we[winner]);
        sel_eprom = !bus.io[winner] && (sel_addr >= EPROM_BASE);
        if (bus.io[winner]) begin
            sel_wait = CNT_W'(IO_WAIT);
        end else if (sel_eprom) begin
            sel_wait = CNT_W'(EPROM_WAIT);
        end else begin
            sel_wait = CNT_W'(RAM_WAIT);
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cyc          <= '0;
            win_q        <= 1'b0;
            wait_cnt     <= '0;
            bus.bus_addr <= '0;
            bus.d_out    <= '0;
            bus.d_oe     <= 1'b0;
            bus.rdata    <= '0;
            bus.ack      <= '0;
            bus.err      <= '0;
            bus.busy     <= 1'b0;
            bus.mr_      <= 1'b1;
            bus.mw_      <= 1'b1;
            bus.ior_     <= 1'b1;
            bus.iow_     <= 1'b1;
        end else begin
            // ack/err are single-cycle: only the STROBE->HOLD edge raises them.
            bus.ack <= '0;
            bus.err <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state        <= SETUP;
                        win_q        <= winner;
                        cyc          <= '{kind: sel_kind, suppress: sel_eprom && bus.we[winner]};
                        wait_cnt     <= sel_wait;
                        bus.bus_addr <= sel_addr;
                        bus.d_out    <= sel_wdata;
                        bus.d_oe     <= bus.we[winner];
                        bus.busy     <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    case (cyc.kind)
                        MEM_RD:  bus.mr_  <= 1'b0;
                        MEM_WR:  bus.mw_  <= cyc.suppress;
                        IO_RD:   bus.ior_ <= 1'b0;
                        default: bus.iow_ <= 1'b0;
                    endcase
                end
                STROBE: begin
                    if (wait_cnt == '0) begin
                        state          <= HOLD;
                        bus.mr_        <= 1'b1;
                        bus.mw_        <= 1'b1;
                        bus.ior_       <= 1'b1;
                        bus.iow_       <= 1'b1;
                        bus.ack[win_q] <= 1'b1;
                        bus.err[win_q] <= cyc.suppress;
                        if (cyc.kind == MEM_RD || cyc.kind == IO_RD) begin
                            bus.rdata <= bus.d_in;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    // HOLD: address and data stay on the bus for this last cycle.
                    state    <= IDLE;
                    bus.d_oe <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Self-checking bench for bus_cycle_arbiter: directed scenarios plus random
// single accesses, checked against a timeline model of each bus cycle.
module tb_bus_cycle_arbiter;

    localparam int          RAM_W   = 1;
    localparam int          EPROM_W = 3;
    localparam int          IO_W    = 2;
    localparam logic [15:0] EBASE   = 16'hF000;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    bit         model_ptr;
    logic [7:0] model_rdata;
    bit         mon_en;

    bus_cycle_arbiter_if bif ();

    bus_cycle_arbiter #(
        .RAM_WAIT   (RAM_W),
        .EPROM_WAIT (EPROM_W),
        .IO_WAIT    (IO_W),
        .EPROM_BASE (EBASE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {bif.mr_, bif.mw_, bif.ior_, bif.iow_};
    endfunction

    always @(negedge clock) begin
        if (mon_en) check("one_strobe_max", 32'($countones(~strobes()) <= 1), 32'd1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One access from an idle bus; the other requester stays quiet.
    task automatic do_access(input int id, input bit w, input bit i, input logic [15:0] a,
                             input logic [7:0] wd, input logic [7:0] din);
        int         wt;
        bit         supp;
        logic [3:0] exp_low;
        logic [1:0] exp_ack;
        logic [1:0] exp_err;
        int         low_cycles;
        wt      = i ? IO_W : ((a >= EBASE) ? EPROM_W : RAM_W);
        supp    = !i && w && (a >= EBASE);
        exp_low = 4'hF;
        if (!i && !w)          exp_low[3] = 1'b0;
        if (!i && w && !supp)  exp_low[2] = 1'b0;
        if (i && !w)           exp_low[1] = 1'b0;
        if (i && w)            exp_low[0] = 1'b0;
        exp_ack = 2'b00;
        exp_ack[id] = 1'b1;
        exp_err = 2'b00;
        exp_err[id] = supp;
        low_cycles = 0;
        if (id == 0) begin
            bif.addr0 = a; bif.wdata0 = wd;
        end else begin
            bif.addr1 = a; bif.wdata1 = wd;
        end
        bif.we[id]  = w;
        bif.io[id]  = i;
        bif.d_in    = din;
        bif.req     = exp_ack;
        for (int j = 1; j <= wt + 4; j++) begin
            @(posedge clock);
            @(negedge clock);
            if (strobes() != 4'hF) low_cycles++;
            if (j <= wt + 3) begin
                check("bus_addr", 32'(bif.bus_addr), 32'(a));
                check("d_out", 32'(bif.d_out), 32'(wd));
                check("d_oe", 32'(bif.d_oe), 32'(w));
                check("busy", 32'(bif.busy), 32'd1);
            end
            if (j == 1) begin
                check("setup_strobes", 32'(strobes()), 32'hF);
            end else if (j <= wt + 2) begin
                check("strobe_pattern", 32'(strobes()), 32'(exp_low));
                check("no_early_ack", 32'(bif.ack), 32'd0);
            end else if (j == wt + 3) begin
                check("hold_strobes", 32'(strobes()), 32'hF);
                check("ack", 32'(bif.ack), 32'(exp_ack));
                check("err", 32'(bif.err), 32'(exp_err));
                if (!w) model_rdata = din;
                check("rdata", 32'(bif.rdata), 32'(model_rdata));
                bif.req = 2'b00;
            end else begin
                check("idle_busy", 32'(bif.busy), 32'd0);
                check("idle_ack", 32'(bif.ack), 32'd0);
                check("idle_d_oe", 32'(bif.d_oe), 32'd0);
                check("idle_addr_kept", 32'(bif.bus_addr), 32'(a));
                check("rdata_held", 32'(bif.rdata), 32'(model_rdata));
            end
        end
        check("strobe_width", 32'(low_cycles), supp ? 32'd0 : 32'(wt + 1));
        model_ptr = (id == 0);
    endtask

    // Both requesters hold RAM reads; grants follow the pointer and alternate.
    task automatic watch_acks(input int n, input int period, input logic [7:0] din);
        int         seen;
        int         last_c;
        logic [1:0] exp_ack;
        seen   = 0;
        last_c = -1;
        bif.d_in = din;
        for (int c = 0; c < 80 && seen < n; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (bif.ack != 2'b00) begin
                exp_ack = 2'b00;
                exp_ack[model_ptr] = 1'b1;
                check("cont_ack_id", 32'(bif.ack), 32'(exp_ack));
                check("cont_err", 32'(bif.err), 32'd0);
                check("cont_rdata", 32'(bif.rdata), 32'(din));
                if (last_c >= 0) check("cont_period", 32'(c - last_c), 32'(period));
                model_rdata = din;
                model_ptr   = !model_ptr;
                last_c      = c;
                seen++;
                if (seen == n) bif.req = 2'b00;
            end
        end
        check("cont_ack_count", 32'(seen), 32'(n));
        @(posedge clock);
        @(negedge clock);
        check("cont_idle", 32'(bif.busy), 32'd0);
    endtask

    initial begin
        bit         found;
        int         id;
        bit         w;
        bit         i;
        logic [15:0] a;
        tests  = 0;
        fails  = 0;
        mon_en = 1'b0;
        reset  = 1'b1;
        bif.req    = 2'b11;
        bif.we     = 2'b00;
        bif.io     = 2'b00;
        bif.addr0  = 16'h0100;
        bif.addr1  = 16'h0200;
        bif.wdata0 = 8'h00;
        bif.wdata1 = 8'h00;
        bif.d_in   = 8'h5A;

        // Reset held two cycles with both requests pending.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_strobes", 32'(strobes()), 32'hF);
        check("rst_d_oe", 32'(bif.d_oe), 32'd0);
        check("rst_ack", 32'(bif.ack), 32'd0);
        check("rst_err", 32'(bif.err), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_bus_addr", 32'(bif.bus_addr), 32'd0);
        check("rst_d_out", 32'(bif.d_out), 32'd0);
        check("rst_rdata", 32'(bif.rdata), 32'd0);
        model_ptr   = 1'b0;
        model_rdata = 8'h00;
        mon_en      = 1'b1;
        reset       = 1'b0;
        watch_acks(4, RAM_W + 4, 8'h5A);

        do_access(0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5);
        do_access(1, 1'b1, 1'b0, 16'hF010, 8'h55, 8'h00);
        do_access(0, 1'b1, 1'b1, 16'h0060, 8'h3C, 8'h00);
        do_access(1, 1'b0, 1'b0, 16'hEFFF, 8'h00, 8'h81);
        do_access(0, 1'b1, 1'b0, 16'hF000, 8'hAA, 8'h00);
        do_access(1, 1'b1, 1'b0, 16'hEFFF, 8'h6B, 8'h00);
        do_access(1, 1'b0, 1'b1, 16'hF800, 8'h00, 8'hC3);
        do_access(0, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h19);

        // Reset while a requester-1 read is strobing.
        bif.we    = 2'b00;
        bif.io    = 2'b00;
        bif.addr1 = 16'h0300;
        bif.addr0 = 16'h0400;
        bif.d_in  = 8'h77;
        bif.req   = 2'b10;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (bif.mr_ == 1'b0) found = 1'b1;
        end
        check("abort_strobe_seen", 32'(found), 32'd1);
        reset   = 1'b1;
        bif.req = 2'b11;
        @(posedge clock);
        @(negedge clock);
        check("abort_strobes", 32'(strobes()), 32'hF);
        check("abort_d_oe", 32'(bif.d_oe), 32'd0);
        check("abort_ack", 32'(bif.ack), 32'd0);
        check("abort_busy", 32'(bif.busy), 32'd0);
        check("abort_rdata", 32'(bif.rdata), 32'd0);
        model_ptr   = 1'b0;
        model_rdata = 8'h00;
        reset       = 1'b0;
        watch_acks(2, RAM_W + 4, 8'h77);

        for (int k = 0; k < 24; k++) begin
            id = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            i  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       a = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
                1:       a = 16'($urandom_range(0, 16'hEFFF));
                default: a = 16'($urandom);
            endcase
            do_access(id, w, i, a, 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_cycle_arbiter.md
# bus_cycle_arbiter

- Sits between two bus requesters (requester 0 = processor, requester 1 = DMA/debug master) and the shared system bus (16-bit address, 8-bit data, `mr_`/`mw_`/`ior_`/`iow_`).
- Arbitrates the two requesters round-robin and sequences one complete bus cycle per grant: setup, strobe with per-region wait states, hold.
- Decodes the RAM/EPROM split; memory writes into EPROM are suppressed and flagged.

## Interface
Parameters:
- `RAM_WAIT`, 1: extra strobe cycles for memory accesses below `EPROM_BASE`.
- `EPROM_WAIT`, 3: extra strobe cycles for memory accesses at or above `EPROM_BASE`.
- `IO_WAIT`, 2: extra strobe cycles for I/O accesses.
- `EPROM_BASE`, 16'hF000: first EPROM address. The EPROM occupies `F000`–`FFFF`.

Ports:
- `clock` in 1: the single clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 2: per-requester access request. Held high with stable fields until `ack`.
- `we` in 2: per-requester write (1) or read (0).
- `io` in 2: per-requester I/O space (1) or memory space (0).
- `addr0`, `addr1` in 16: requester addresses.
- `wdata0`, `wdata1` in 8: requester write data.
- `ack` out 2: one-cycle completion pulse for the granted requester.
- `err` out 2: pulses with `ack` when the write was suppressed (EPROM).
- `rdata` out 8: read data; valid in the `ack` cycle and held until the next read completes.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `bus_addr` out 16: address driven onto the bus.
- `d_out` out 8: write data driven onto the bus.
- `d_oe` out 1: data bus output enable.
- `d_in` in 8: data bus read value.
- `mr_`, `mw_`, `ior_`, `iow_` out 1 each: active-low strobes.

## Operation
- **Reset values** (next edge with `reset`=1):
  - FSM=IDLE, all strobes 1, `d_oe`=0.
  - `bus_addr`=0, `d_out`=0, `rdata`=0, `ack`=0, `err`=0, `busy`=0.
  - Round-robin pointer=0.
- **FSM states:** IDLE → SETUP → STROBE → HOLD → IDLE.
- **IDLE:** if any `req` is high, select the winner and go to SETUP. Winner selection:
  - Only one request high: that requester wins.
  - Both high: the requester named by the pointer wins.
  - After any grant, the pointer is set to the non-winner.
- **SETUP:**
  - Latch the winner's `addr`/`we`/`io`/`wdata` into cycle registers and drive `bus_addr`/`d_out`.
  - `d_oe`=we. All strobes stay inactive.
  - Load the wait counter with W: `IO_WAIT` if io, else `EPROM_WAIT` if addr ≥ `EPROM_BASE`, else `RAM_WAIT`.
- **STROBE:**
  - Assert exactly one strobe:
    - `mr_`: !io & !we
    - `mw_`: !io & we & addr < `EPROM_BASE`
    - `ior_`: io & !we
    - `iow_`: io & we
  - An EPROM write asserts no strobe but still takes the same timing.
  - Stay W+1 cycles. On the last cycle, register `d_in` into `rdata` (reads only).
- **HOLD:**
  - All strobes 1; `bus_addr`/`d_out`/`d_oe` unchanged.
  - `ack[winner]`=1. `err[winner]`=1 if this was an EPROM write.
  - Next state: IDLE.
- **IDLE outputs:** `d_oe`=0. `bus_addr` and `d_out` keep their last values.
- Latched fields are used for the whole cycle. Changes to or withdrawal of `req` after grant are ignored; the cycle completes and `ack` is still issued.
- I/O addresses use all 16 bits; I/O has no region decode.
- Wait-counter width is the log2 ceiling of (max wait + 1). It counts down and never wraps.

## Timing
- `req` sampled at edge E0 (in IDLE) → SETUP at E0+1 → STROBE at E0+2 through E0+2+W → HOLD (`ack` high) at E0+3+W → IDLE at E0+4+W.
- Access latency: `ack` appears W+3 edges after the sampling edge.
- Back-to-back throughput: one access per W+4 cycles. A pending request is sampled at E0+4+W.
- Strobe low width: exactly W+1 cycles, with at least one strobe-inactive cycle before (SETUP) and after (HOLD).
- No two strobes are ever low simultaneously.
- `ack` and `err` are single-cycle and registered.
- `reset` mid-cycle: next edge forces the reset values, and no `ack` is issued for the aborted cycle. Requests still held are re-arbitrated from pointer=0.

## Structure
- Shared package `bus_defs`:
  - FSM state encoding (IDLE/SETUP/STROBE/HOLD).
  - Cycle-kind constants (MEM_RD, MEM_WR, IO_RD, IO_WR).
  - `EPROM_BASE` default, bus widths (16 address, 8 data).
- One sub-module: `rr_arbiter2`. Two-way round-robin with registered pointer; inputs `req`, `grant_en`; outputs `winner`.

## Test plan
1. **Reset:** `reset` high 2 cycles with `req`=2'b11 → all strobes 1, `d_oe`=0, `ack`=0, `busy`=0. The first grant after release goes to requester 0.
2. **RAM read:** `req[0]`, addr 16'h1234, RAM_WAIT=1, `d_in`=8'hA5.
   - `mr_` low at E0+2 and E0+3.
   - `ack[0]` at E0+4 with `rdata`=8'hA5, `err`=0.
3. **EPROM write:** `req[1]`, we, addr 16'hF010, wdata 8'h55.
   - `mw_` never low.
   - `ack[1]` and `err[1]` at E0+6.
4. **Contention:** both `req` held high continuously, RAM reads.
   - Acks alternate 0,1,0,1.
   - One `ack` every 5 cycles.
5. **I/O write:** `req[0]`, io, we, addr 16'h0060, wdata 8'h3C, IO_WAIT=2.
   - `iow_` low for 3 cycles.
   - `d_out`=8'h3C and `d_oe`=1 from SETUP through HOLD.
   - `ack[0]` at E0+5.
6. **Reset during STROBE:** assert `reset` during STROBE of a requester-1 read.
   - Next edge: strobes 1, `d_oe`=0, no `ack`.
   - After release, with both requests held, requester 0 is granted first.
